// File: rtl/digit_serial_mult_ctrl_pkg.sv
// Shared types and constants for the digit-serial multiplier controller.
package digit_serial_mult_ctrl_pkg;

   localparam int DEF_A_W      = 11;
   localparam int DEF_DIGIT_W  = 3;
   localparam int DEF_B_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Product width needed to hold an exact a*b without truncation.
   function automatic int p_width(input int a_w, input int digit_w, input int b_digits);
      return a_w + digit_w * b_digits;
   endfunction

endpackage

// File: rtl/digit_serial_mult_ctrl_digit_mult_shiftadd.sv
// Combinational A_W x DIGIT_W unsigned multiply: sum of shifted copies of A
// selected by the digit bits.
module digit_mult_shiftadd #(
   parameter int A_W     = 11,
   parameter int DIGIT_W = 3
) (
   input  logic [A_W-1:0]         a_i,
   input  logic [DIGIT_W-1:0]     digit_i,
   output logic [A_W+DIGIT_W-1:0] partial_o
);

   localparam int PART_W = A_W + DIGIT_W;

   // NOTE: the output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      partial_o = '0;
      for (int j = 0; j < DIGIT_W; j++) begin
         if (digit_i[j]) begin
            partial_o = partial_o + (PART_W'(a_i) << j);
         end
      end
   end

endmodule

// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial multiply controller: one DIGIT_W digit of B per cycle, LSB first,
// shifted partial products accumulated into an exact P_W-bit product.
module digit_serial_mult_ctrl
   import digit_serial_mult_ctrl_pkg::*;
#(
   parameter  int A_W      = DEF_A_W,
   parameter  int DIGIT_W  = DEF_DIGIT_W,
   parameter  int B_DIGITS = DEF_B_DIGITS,
   localparam int B_W      = DIGIT_W * B_DIGITS,
   localparam int P_W      = p_width(A_W, DIGIT_W, B_DIGITS)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P_W-1:0] product,
   output logic           busy
);

   localparam int                PART_W   = A_W + DIGIT_W;
   localparam int                IDX_W    = (B_DIGITS > 1) ? $clog2(B_DIGITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(B_DIGITS - 1);

   state_e             state_q;
   logic [A_W-1:0]     a_q;
   logic [B_W-1:0]     b_q;
   logic [P_W-1:0]     acc_q;
   logic [P_W-1:0]     acc_d;
   logic [IDX_W-1:0]   idx_q;
   logic [P_W-1:0]     product_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [DIGIT_W-1:0] digit;
   logic [PART_W-1:0]  partial;

   assign digit = b_q[idx_q * DIGIT_W +: DIGIT_W];

   digit_mult_shiftadd #(
      .A_W     (A_W),
      .DIGIT_W (DIGIT_W)
   ) u_digit_mult (
      .a_i       (a_q),
      .digit_i   (digit),
      .partial_o (partial)
   );

   // Sums never exceed P_W bits, so this add cannot wrap.
   assign acc_d = acc_q + (P_W'(partial) << (DIGIT_W * int'(idx_q)));

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  acc_q      <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               if (idx_q == LAST_IDX) begin
                  product_q   <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               // Operands offered during this cycle are not taken; IDLE accepts them next cycle.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Directed self-checking bench for digit_serial_mult_ctrl (11 x 12 bit, 3-bit digits).
module tb_digit_serial_mult_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] a;
   logic [11:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] product;
   logic        busy;

   int checks = 0;
   int errors = 0;

   digit_serial_mult_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transaction with out_ready high: checks latency, result, and return to IDLE.
   task automatic run_op(input logic [10:0] av, input logic [11:0] bv,
                         input logic [22:0] exp, input string tag);
      int   lat;
      logic rdy_seen;
      a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 11'h5A5; b = 12'hA5A;
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 20) begin
         rdy_seen = rdy_seen | in_ready;
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, 5);
      check({tag, "_prod"}, product, exp);
      check({tag, "_rdy_low"}, {rdy_seen, in_ready}, 2'b00);
      tick();
      check({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   initial begin
      int   k;
      int   cyc;
      int   last_cyc;
      int   lat;
      logic acc_now;
      logic [10:0] bb_a [3];
      logic [11:0] bb_b [3];
      logic [22:0] bb_p [3];
      logic [10:0] ra;
      logic [11:0] rb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #12;
      check("rst_outputs", {in_ready, out_valid, busy}, 3'b100);
      check("rst_product", product, 23'd0);
      rst_n = 1'b1;
      tick();

      // Basic, full-scale and all-ones digit cases.
      run_op(11'd5, 12'd3, 23'd15, "t1");
      run_op(11'd2047, 12'd4095, 23'h7FE801, "t2_max");
      run_op(11'd2047, 12'h007, 23'd14329, "t2_d7");
      // Zero operands still take the full latency.
      run_op(11'd0, 12'd4095, 23'd0, "t3_a0");
      run_op(11'd1234, 12'd0, 23'd0, "t3_b0");

      // Backpressure in DONE with ignored in_valid pulses.
      a = 11'd100; b = 12'd200; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin tick(); k++; end
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0]; a = 11'd1; b = 12'd1;
         tick();
         check("t4_hold_valid", {out_valid, in_ready, busy}, 3'b101);
         check("t4_hold_prod", product, 23'd20000);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("t4_release", {in_ready, out_valid, busy}, 3'b100);
      run_op(11'd3, 12'd4, 23'd12, "t4_after");

      // Back-to-back with in_valid held high.
      bb_a[0] = 11'd11;   bb_b[0] = 12'd13;   bb_p[0] = 23'd143;
      bb_a[1] = 11'd2047; bb_b[1] = 12'd4095; bb_p[1] = 23'h7FE801;
      bb_a[2] = 11'd600;  bb_b[2] = 12'd3;    bb_p[2] = 23'd1800;
      k = 0; cyc = 0; last_cyc = 0;
      a = bb_a[0]; b = bb_b[0]; in_valid = 1'b1; out_ready = 1'b1;
      while (k < 3 && cyc < 60) begin
         acc_now = in_valid & in_ready;
         tick();
         cyc++;
         if (acc_now) begin
            if (k < 2) begin
               a = bb_a[k+1]; b = bb_b[k+1];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            check("t5_prod", product, bb_p[k]);
            if (k > 0) check("t5_spacing", cyc - last_cyc, 6);
            last_cyc = cyc;
            k++;
         end
      end
      in_valid = 1'b0;
      check("t5_count", k, 3);
      tick();

      // Reset in the middle of RUN (idx == 2).
      a = 11'd500; b = 12'd777; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_outputs", {in_ready, out_valid, busy}, 3'b100);
      check("t6_rst_product", product, 23'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op(11'd7, 12'd9, 23'd63, "t6_after");

      // Random operands with random backpressure.
      for (int i = 0; i < 200; i++) begin
         ra = 11'($urandom); rb = 12'($urandom);
         a = ra; b = rb; in_valid = 1'b1; out_ready = 1'b0;
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin tick(); lat++; end
         check("rnd_lat", lat, 5);
         check("rnd_prod", product, 23'(ra) * 23'(rb));
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
            tick();
            check("rnd_hold", {out_valid, product}, {1'b1, 23'(ra) * 23'(rb)});
         end
         out_ready = 1'b1;
         tick();
         check("rnd_idle", {in_ready, out_valid}, 2'b10);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
